// File: rtl/osc_freq_meter.sv
// rtl/osc_freq_meter.sv - gated rising-edge frequency meter for an asynchronous oscillator node
// Results leave over a valid/ready handshake; a watchdog flags a stalled oscillator.
module osc_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int GATE_CYCLES = 1000,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             osc_in,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             stalled,
  output logic             busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [WW-1:0]    WD_MAX    = WW'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, ARM, GATE, REPORT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   osc_edge;
  logic [CNT_W-1:0]       edge_cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   ovf_int;
  logic                   ovf_next;
  logic [GW-1:0]          gate_cnt;
  logic [WW-1:0]          wd_cnt;
  logic [WW-1:0]          wd_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign osc_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Saturating edge count; reaching full scale marks the window as overflowed.
  always_comb begin
    cnt_next = edge_cnt;
    if (osc_edge && (edge_cnt != CNT_MAX)) begin
      cnt_next = edge_cnt + CNT_W'(1);
    end
    ovf_next = ovf_int | (cnt_next == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      edge_cnt    <= '0;
      gate_cnt    <= '0;
      ovf_int     <= 1'b0;
      count       <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          edge_cnt <= '0;
          gate_cnt <= '0;
          ovf_int  <= 1'b0;
          state    <= GATE;
        end
        GATE: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            edge_cnt <= cnt_next;
            ovf_int  <= ovf_next;
            gate_cnt <= gate_cnt + GW'(1);
            if (gate_cnt == GATE_LAST) begin
              count       <= cnt_next;
              overflow    <= ovf_next;
              count_valid <= 1'b1;
              state       <= REPORT;
            end
          end
        end
        REPORT: begin
          // The pending result survives en dropping; only the handshake releases it.
          if (count_ready) begin
            count_valid <= 1'b0;
            if (en) begin
              state <= ARM;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wd_next = wd_cnt;
    if (!en || osc_edge) begin
      wd_next = '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_next = wd_cnt + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      stalled <= 1'b0;
    end else begin
      wd_cnt  <= wd_next;
      stalled <= (wd_next == WD_MAX);
    end
  end

endmodule

// File: tb/tb_osc_freq_meter.sv
// tb/tb_osc_freq_meter.sv - randomized directed bench for osc_freq_meter
// Reference: per-cycle edge map and watchdog streak, windows derived from arm cycles.
module tb_osc_freq_meter;

  localparam int G     = 100;
  localparam int T     = 256;
  localparam int S     = 2;
  localparam int MAXC  = 8192;

  logic        clk = 1'b0;
  logic        rst_n, en, osc_in, count_ready;
  logic [15:0] count_a;
  logic [3:0]  count_b;
  logic        ovf_a, ovf_b, valid_a, valid_b, stalled_a, stalled_b, busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int streak  = 0;
  int osc_period = 0;
  int osc_phase  = 0;
  int last_a = 0;
  int last_b = 0;
  int last_ovf_a = 0;
  int last_ovf_b = 0;
  logic edge_at [0:MAXC-1];

  always #5 clk = ~clk;

  osc_freq_meter #(.CNT_W(16), .GATE_CYCLES(G), .SYNC_STAGES(S), .TIMEOUT(T)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .osc_in(osc_in),
    .count(count_a), .overflow(ovf_a), .count_valid(valid_a), .count_ready(count_ready),
    .stalled(stalled_a), .busy(busy_a));

  osc_freq_meter #(.CNT_W(4), .GATE_CYCLES(G), .SYNC_STAGES(S), .TIMEOUT(T)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .osc_in(osc_in),
    .count(count_b), .overflow(ovf_b), .count_valid(valid_b), .count_ready(count_ready),
    .stalled(stalled_b), .busy(busy_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance to the next cycle, drive the oscillator and check the watchdog.
  task automatic tick();
    logic nv;
    if (!rst_n) streak = 0;
    else if (en && !edge_at[cyc]) streak++;
    else streak = 0;
    @(negedge clk);
    cyc++;
    if (osc_period == 0) begin
      nv = 1'b0;
      osc_phase = 0;
    end else begin
      osc_phase = (osc_phase + 1 >= osc_period) ? 0 : osc_phase + 1;
      nv = (osc_phase < osc_period / 2);
    end
    if (nv && !osc_in && (cyc + S < MAXC)) edge_at[cyc + S] = 1'b1;
    osc_in = nv;
    chk("stalled_a", 32'(stalled_a), 32'(streak >= T));
    chk("stalled_b", 32'(stalled_b), 32'(streak >= T));
  endtask

  function automatic int edges_in(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (i < MAXC && edge_at[i]) n++;
    return n;
  endfunction

  // Window armed in cycle a: gate cycles a+1..a+G, result visible in cycle a+G+1.
  task automatic expect_window(input int a);
    int raw;
    while (cyc < a + G) tick();
    chk("valid_before_end", 32'(valid_a), 32'(0));
    tick();
    raw = edges_in(a + 1, a + G);
    last_a = (raw > 65535) ? 65535 : raw;
    last_b = (raw > 15) ? 15 : raw;
    last_ovf_a = (raw >= 65535) ? 1 : 0;
    last_ovf_b = (raw >= 15) ? 1 : 0;
    chk("valid_a", 32'(valid_a), 32'(1));
    chk("valid_b", 32'(valid_b), 32'(1));
    chk("count_a", 32'(count_a), 32'(last_a));
    chk("count_b", 32'(count_b), 32'(last_b));
    chk("ovf_a", 32'(ovf_a), 32'(last_ovf_a));
    chk("ovf_b", 32'(ovf_b), 32'(last_ovf_b));
    chk("busy_report", 32'(busy_a), 32'(1));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_count"}, 32'(count_a) | 32'(count_b), 32'(0));
    chk({tag, "_ovf"}, 32'(ovf_a) | 32'(ovf_b), 32'(0));
    chk({tag, "_valid"}, 32'(valid_a) | 32'(valid_b), 32'(0));
    chk({tag, "_stalled"}, 32'(stalled_a) | 32'(stalled_b), 32'(0));
    chk({tag, "_busy"}, 32'(busy_a) | 32'(busy_b), 32'(0));
  endtask

  initial begin
    int a, v, periods[4];
    for (int i = 0; i < MAXC; i++) edge_at[i] = 1'b0;
    rst_n = 1'b0; en = 1'b0; osc_in = 1'b0; count_ready = 1'b1;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_zero("reset");
    end
    rst_n = 1'b1;
    tick();
    chk_zero("post_reset_idle");

    // Nominal and overflow windows, back to back with ready held high
    osc_period = 10;
    for (int i = 0; i < 5; i++) tick();
    en = 1'b1;
    a = cyc + 1;
    periods[0] = 10; periods[1] = 4;
    periods[2] = int'($urandom_range(4, 40)); periods[3] = int'($urandom_range(4, 40));
    for (int w = 0; w < 4; w++) begin
      osc_period = periods[w];
      expect_window(a);
      a = a + G + 2;
    end

    // Backpressure: result held for 50 cycles while the oscillator changes
    v = cyc;
    count_ready = 1'b0;
    osc_period = int'($urandom_range(4, 40));
    for (int i = 1; i < 50; i++) begin
      tick();
      chk("bp_valid", 32'(valid_a), 32'(1));
      chk("bp_count_a", 32'(count_a), 32'(last_a));
      chk("bp_count_b", 32'(count_b), 32'(last_b));
      chk("bp_busy", 32'(busy_a), 32'(1));
    end
    tick();
    count_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(valid_a), 32'(0));
    chk("bp_release_busy", 32'(busy_a), 32'(1));
    a = v + 51;
    expect_window(a);

    // Abort at gate cycle 50
    a = cyc + 1;
    while (cyc < a + 1 + 50) tick();
    en = 1'b0;
    tick();
    chk("abort_busy", 32'(busy_a), 32'(0));
    for (int i = 0; i < 150; i++) begin
      tick();
      chk("abort_valid", 32'(valid_a), 32'(0));
      chk("abort_count_a", 32'(count_a), 32'(last_a));
      chk("abort_ovf_b", 32'(ovf_b), 32'(last_ovf_b));
    end

    // Stall: silent oscillator gives a zero count and trips the watchdog
    osc_period = 0;
    for (int i = 0; i < 10; i++) tick();
    en = 1'b1;
    a = cyc + 1;
    expect_window(a);
    while (cyc < a - 2 + T) tick();
    chk("stall_not_yet", 32'(stalled_a), 32'(0));
    tick();
    chk("stall_rise", 32'(stalled_a), 32'(1));
    osc_period = 10;
    for (int i = 0; i < 30; i++) tick();
    chk("stall_cleared", 32'(stalled_a), 32'(0));
    osc_period = 0;
    while (cyc < a - 1 + 2 * T + 40) tick();
    chk("stall_again", 32'(stalled_a), 32'(1));
    en = 1'b0;
    tick();
    chk("stall_en_low", 32'(stalled_a), 32'(0));

    // Reset in the middle of a gate window
    for (int i = 0; i < 5; i++) tick();
    osc_period = int'($urandom_range(4, 40));
    en = 1'b1;
    a = cyc + 1;
    while (cyc < a + 26) tick();
    osc_period = 0;
    while (cyc < a + 41) tick();
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    tick();
    chk_zero("reset_hold1");
    tick();
    chk_zero("reset_hold2");
    rst_n = 1'b1;
    osc_period = int'($urandom_range(4, 40));
    expect_window(cyc + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
